// File: rtl/rtc_bus_engine.sv
// rtc_bus_engine
//   Drives single-byte and burst read/write transactions on the RTC multiplexed
//   address/data bus. Every byte has an address phase followed by a data phase.
//   Each phase is setup / strobe / hold, with a CS-high gap between bytes.
//   All RTC strobes are active-low and every pin is registered.
//
// Ports
//   CLK, RST          system clock, asynchronous active-high reset
//   req, rw           start request (IDLE only); rw=1 write, 0 read
//   start_addr, count first register address and byte count, latched with req
//   wdata, wdata_valid, wdata_ready   write byte stream (consumed when both high)
//   rdata, rdata_valid                last read byte and its one-cycle strobe
//   busy, done, err                   status; err is sticky until the next req
//   bus_out, bus_oe, bus_in           AD bus drive value, drive enable, readback
//   AD, CS, RD, WR                    RTC strobes, active-low
//
// Optional feature
//   RTC_BUS_TIMEOUT_EN: abort a write whose data does not arrive within
//   TIMEOUT cycles of waiting (err=1, done pulses, CS never goes low).
//
// State      | meaning
// IDLE       | waiting for req
// WAIT_DATA  | write only: wdata_ready high until a byte is consumed
// A_SETUP    | CS low, address driven, AD low
// A_STROBE   | WR low to latch the address
// A_HOLD     | WR high, address still driven
// D_SETUP    | AD high; write byte driven, or bus released for a read
// D_STROBE   | WR or RD low; read data sampled on the last cycle
// D_HOLD     | strobe high, CS still low; byte count decrements on exit
// GAP        | CS high between bytes; done pulses in its last cycle
// FINISH     | one busy cycle carrying done (zero count or abort)
module rtc_bus_engine #(
    parameter int DATA_W    = 8,
    parameter int T_SETUP   = 1,
    parameter int T_PULSE   = 2,
    parameter int T_HOLD    = 1,
    parameter int T_GAP     = 2,
    parameter int BURST_MAX = 16,
    parameter int TIMEOUT   = 255,
    localparam int CNT_W    = $clog2(BURST_MAX + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req,
    input  logic              rw,
    input  logic [DATA_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in,
    output logic              AD,
    output logic              CS,
    output logic              RD,
    output logic              WR
);

    if (T_SETUP < 1 || T_SETUP > 15 || T_PULSE < 1 || T_PULSE > 15 ||
        T_HOLD < 1 || T_HOLD > 15 || T_GAP < 1 || T_GAP > 15 ||
        BURST_MAX < 1 || TIMEOUT < 1) begin : g_param_check
        $error("rtc_bus_engine: phase timing must be 1..15, BURST_MAX and TIMEOUT >= 1");
    end

    typedef enum logic [3:0] {
        IDLE, WAIT_DATA, A_SETUP, A_STROBE, A_HOLD,
        D_SETUP, D_STROBE, D_HOLD, GAP, FINISH
    } state_t;

    typedef struct packed {
        logic              ad;
        logic              cs;
        logic              rd;
        logic              wr;
        logic              oe;
        logic [DATA_W-1:0] bus;
    } pins_t;

    // Phase timers are down-counters loaded with length-1; terminal count is 0.
    localparam logic [3:0] LD_SETUP = 4'(T_SETUP - 1);
    localparam logic [3:0] LD_PULSE = 4'(T_PULSE - 1);
    localparam logic [3:0] LD_HOLD  = 4'(T_HOLD - 1);
    localparam logic [3:0] LD_GAP   = 4'(T_GAP - 1);

    state_t             state;
    pins_t              pins;
    logic [3:0]         tmr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_in;
    logic [DATA_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wbyte_q;
    logic               rw_q;

`ifdef RTC_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LD = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0]    to_cnt;
`endif

    assign cnt_in  = (count > CNT_W'(BURST_MAX)) ? CNT_W'(BURST_MAX) : count;

    assign AD      = pins.ad;
    assign CS      = pins.cs;
    assign RD      = pins.rd;
    assign WR      = pins.wr;
    assign bus_oe  = pins.oe;
    assign bus_out = pins.bus;

    // Pin values for the state being entered; keeps the strobes registered.
    function automatic pins_t pins_for(state_t s, logic is_wr,
                                       logic [DATA_W-1:0] a, logic [DATA_W-1:0] d);
        pins_t p;
        p.ad  = 1'b1;
        p.cs  = 1'b1;
        p.rd  = 1'b1;
        p.wr  = 1'b1;
        p.oe  = 1'b0;
        p.bus = '0;
        case (s)
            A_SETUP, A_STROBE, A_HOLD: begin
                p.cs  = 1'b0;
                p.ad  = 1'b0;
                p.oe  = 1'b1;
                p.bus = a;
                p.wr  = (s != A_STROBE);
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                p.cs  = 1'b0;
                p.oe  = is_wr;
                p.bus = is_wr ? d : '0;
                if (s == D_STROBE) begin
                    if (is_wr) p.wr = 1'b0;
                    else       p.rd = 1'b0;
                end
            end
            default: ;
        endcase
        return p;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            pins        <= pins_for(IDLE, 1'b0, '0, '0);
            tmr         <= '0;
            cnt         <= '0;
            addr_q      <= '0;
            wbyte_q     <= '0;
            rw_q        <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            wdata_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef RTC_BUS_TIMEOUT_EN
            to_cnt      <= TO_LD;
`endif
        end else begin
            done        <= 1'b0;
            rdata_valid <= 1'b0;
`ifdef RTC_BUS_TIMEOUT_EN
            if (state != WAIT_DATA) to_cnt <= TO_LD;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        rw_q   <= rw;
                        addr_q <= start_addr;
                        cnt    <= cnt_in;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        if (cnt_in == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else if (rw) begin
                            state       <= WAIT_DATA;
                            wdata_ready <= 1'b1;
                        end else begin
                            state <= A_SETUP;
                            tmr   <= LD_SETUP;
                            pins  <= pins_for(A_SETUP, 1'b0, start_addr, wbyte_q);
                        end
                    end
                end
                WAIT_DATA: begin
                    if (wdata_valid) begin
                        wbyte_q     <= wdata;
                        wdata_ready <= 1'b0;
                        state       <= A_SETUP;
                        tmr         <= LD_SETUP;
                        pins        <= pins_for(A_SETUP, 1'b1, addr_q, wdata);
                    end
`ifdef RTC_BUS_TIMEOUT_EN
                    else if (to_cnt == '0) begin
                        wdata_ready <= 1'b0;
                        err         <= 1'b1;
                        done        <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        to_cnt <= to_cnt - TO_W'(1);
                    end
`endif
                end
                A_SETUP: begin
                    if (tmr == '0) begin
                        state <= A_STROBE;
                        tmr   <= LD_PULSE;
                        pins  <= pins_for(A_STROBE, rw_q, addr_q, wbyte_q);
                    end else tmr <= tmr - 4'd1;
                end
                A_STROBE: begin
                    if (tmr == '0) begin
                        state <= A_HOLD;
                        tmr   <= LD_HOLD;
                        pins  <= pins_for(A_HOLD, rw_q, addr_q, wbyte_q);
                    end else tmr <= tmr - 4'd1;
                end
                A_HOLD: begin
                    if (tmr == '0) begin
                        state <= D_SETUP;
                        tmr   <= LD_SETUP;
                        pins  <= pins_for(D_SETUP, rw_q, addr_q, wbyte_q);
                    end else tmr <= tmr - 4'd1;
                end
                D_SETUP: begin
                    if (tmr == '0) begin
                        state <= D_STROBE;
                        tmr   <= LD_PULSE;
                        pins  <= pins_for(D_STROBE, rw_q, addr_q, wbyte_q);
                    end else tmr <= tmr - 4'd1;
                end
                D_STROBE: begin
                    if (tmr == '0) begin
                        if (!rw_q) begin
                            rdata       <= bus_in;
                            rdata_valid <= 1'b1;
                        end
                        state <= D_HOLD;
                        tmr   <= LD_HOLD;
                        pins  <= pins_for(D_HOLD, rw_q, addr_q, wbyte_q);
                    end else tmr <= tmr - 4'd1;
                end
                D_HOLD: begin
                    if (tmr == '0) begin
                        cnt    <= cnt - CNT_W'(1);
                        addr_q <= addr_q + DATA_W'(1);
                        state  <= GAP;
                        tmr    <= LD_GAP;
                        pins   <= pins_for(GAP, rw_q, addr_q, wbyte_q);
                        // A one-cycle gap is also the last gap cycle.
                        if (cnt == CNT_W'(1) && T_GAP == 1) done <= 1'b1;
                    end else tmr <= tmr - 4'd1;
                end
                GAP: begin
                    if (tmr == '0) begin
                        if (cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (rw_q) begin
                            state       <= WAIT_DATA;
                            wdata_ready <= 1'b1;
                        end else begin
                            state <= A_SETUP;
                            tmr   <= LD_SETUP;
                            pins  <= pins_for(A_SETUP, 1'b0, addr_q, wbyte_q);
                        end
                    end else begin
                        tmr <= tmr - 4'd1;
                        if (tmr == 4'd1 && cnt == '0) done <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
